// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters.
// Grants are registered one-hot with an encoded owner ID, each tenure is
// bounded to MAX_HOLD cycles with a timeout pulse on forced release, and
// new grants are gated by enable.
module rr_grant_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 16,
   parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               timeout
);

   localparam int HC_W = $clog2(MAX_HOLD) + 1;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [HC_W-1:0]   hold_cnt;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [ID_W-1:0]      win_off;
   logic [ID_W:0]        win_sum;
   logic [ID_W-1:0]      win_id;
   logic [ID_W-1:0]      ptr_next;
   logic                 owner_req;

   // Rotate req so bit 0 is the requester at ptr, then pick the lowest set
   // bit and map the offset back to an absolute index modulo NUM_REQ.
   always_comb begin
      req_dbl = {req, req};
      req_rot = NUM_REQ'(req_dbl >> ptr);
      win_off = '0;
      for (int unsigned j = NUM_REQ; j > 0; j--) begin
         if (req_rot[j-1]) begin
            win_off = ID_W'(j - 1);
         end
      end
      win_sum = {1'b0, ptr} + {1'b0, win_off};
      if (win_sum >= (ID_W+1)'(NUM_REQ)) begin
         win_id = ID_W'(win_sum - (ID_W+1)'(NUM_REQ));
      end else begin
         win_id = ID_W'(win_sum);
      end
   end

   // Owner still requesting, and the pointer position just past the owner.
   always_comb begin
      owner_req = |(req & gnt);
      if (gnt_id == ID_W'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = gnt_id + ID_W'(1);
      end
   end

   // IDLE/GRANT state machine with all outputs registered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (enable && (|req)) begin
                  state    <= GRANT;
                  gnt      <= NUM_REQ'(1) << win_id;
                  gnt_id   <= win_id;
                  hold_cnt <= '0;
               end else begin
                  gnt <= '0;
               end
            end
            GRANT: begin
               if (!owner_req) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  ptr     <= ptr_next;
                  timeout <= 1'b0;
               end else if (hold_cnt == HC_W'(MAX_HOLD - 1)) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  ptr     <= ptr_next;
                  timeout <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HC_W'(1);
                  timeout  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               gnt     <= '0;
               timeout <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_valid = |gnt;

endmodule
